wb_pipe_reg: RTL and testbench

Parametrised MEM→WB pipeline register for the 32-bit MIPS pipeline datapath. It carries the writeback bundle through DEPTH register stages, qualified by a per-stage valid bit. It supports pipeline stall and flush, selects the final writeback data (memory read data or ALU result), and exposes combinational forwarding-hit data from every in-flight stage to the hazard/forwarding unit.

---
 rtl/wb_pipe_reg.sv | 121 ++++++++++++
 tb/tb_wb_pipe_reg.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_pipe_reg.sv
// MEM->WB pipeline register for the 32-bit MIPS datapath.
// Carries the writeback bundle through DEPTH stages and supports stall and flush.
// Selects the writeback data and reports forwarding hits for two source registers.
module wb_pipe_reg #(
   parameter int DATA_W = 32,
   parameter int REG_W  = 5,
   parameter int DEPTH  = 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              stall,
   input  logic              flush,
   input  logic              in_valid,
   input  logic              in_we,
   input  logic              in_mem_to_reg,
   input  logic [DATA_W-1:0] in_read_data,
   input  logic [DATA_W-1:0] in_result,
   input  logic [REG_W-1:0]  in_reg_dst,
   input  logic [REG_W-1:0]  src_a,
   input  logic [REG_W-1:0]  src_b,
   output logic              out_valid,
   output logic              out_we,
   output logic [DATA_W-1:0] out_wdata,
   output logic [REG_W-1:0]  out_reg_dst,
   output logic              hit_a,
   output logic              hit_b,
   output logic [DATA_W-1:0] fwd_a,
   output logic [DATA_W-1:0] fwd_b,
   output logic              busy
);

   // Stage 0 is the input side and stage DEPTH-1 drives the outputs.
   logic [DEPTH-1:0]             valid_q, valid_d;
   logic [DEPTH-1:0]             we_q, we_d;
   logic [DEPTH-1:0]             m2r_q, m2r_d;
   logic [DEPTH-1:0][DATA_W-1:0] rdata_q, rdata_d;
   logic [DEPTH-1:0][DATA_W-1:0] result_q, result_d;
   logic [DEPTH-1:0][REG_W-1:0]  dst_q, dst_d;
   logic [DEPTH-1:0][DATA_W-1:0] wb_data;

   // Next state: flush kills the control bits only; stall holds everything.
   always_comb begin
      valid_d  = valid_q;
      we_d     = we_q;
      m2r_d    = m2r_q;
      rdata_d  = rdata_q;
      result_d = result_q;
      dst_d    = dst_q;
      if (flush) begin
         valid_d = '0;
         we_d    = '0;
      end else if (!stall) begin
         valid_d[0]  = in_valid;
         we_d[0]     = in_we;
         m2r_d[0]    = in_mem_to_reg;
         rdata_d[0]  = in_read_data;
         result_d[0] = in_result;
         dst_d[0]    = in_reg_dst;
         for (int s = 1; s < DEPTH; s++) begin
            valid_d[s]  = valid_q[s-1];
            we_d[s]     = we_q[s-1];
            m2r_d[s]    = m2r_q[s-1];
            rdata_d[s]  = rdata_q[s-1];
            result_d[s] = result_q[s-1];
            dst_d[s]    = dst_q[s-1];
         end
      end
   end

   // State register; reset clears every field and wins over stall and flush.
   always_ff @(posedge clk) begin
      if (rst) begin
         valid_q  <= '0;
         we_q     <= '0;
         m2r_q    <= '0;
         rdata_q  <= '0;
         result_q <= '0;
         dst_q    <= '0;
      end else begin
         valid_q  <= valid_d;
         we_q     <= we_d;
         m2r_q    <= m2r_d;
         rdata_q  <= rdata_d;
         result_q <= result_d;
         dst_q    <= dst_d;
      end
   end

   // Writeback data for every stage, so forwarding sees the same selection as writeback.
   always_comb begin
      wb_data = '0;
      for (int s = 0; s < DEPTH; s++) begin
         wb_data[s] = m2r_q[s] ? rdata_q[s] : result_q[s];
      end
   end

   // Forwarding: walk oldest to youngest so the youngest qualifying stage wins.
   always_comb begin
      hit_a = 1'b0;
      hit_b = 1'b0;
      fwd_a = '0;
      fwd_b = '0;
      for (int s = DEPTH - 1; s >= 0; s--) begin
         if (valid_q[s] && we_q[s] && (src_a != '0) && (dst_q[s] == src_a)) begin
            hit_a = 1'b1;
            fwd_a = wb_data[s];
         end
         if (valid_q[s] && we_q[s] && (src_b != '0) && (dst_q[s] == src_b)) begin
            hit_b = 1'b1;
            fwd_b = wb_data[s];
         end
      end
   end

   assign out_valid   = valid_q[DEPTH-1];
   assign out_we      = valid_q[DEPTH-1] & we_q[DEPTH-1] & (dst_q[DEPTH-1] != '0);
   assign out_wdata   = wb_data[DEPTH-1];
   assign out_reg_dst = dst_q[DEPTH-1];
   assign busy        = |valid_q;

endmodule

// File: tb/tb_wb_pipe_reg.sv
// Bench for wb_pipe_reg with DEPTH=1, 2 and 3 instances sharing one stimulus stream.
module tb_wb_pipe_reg;

   logic        clk = 1'b0;
   logic        rst, stall, flush;
   logic        in_valid, in_we, in_mem_to_reg;
   logic [31:0] in_read_data, in_result;
   logic [4:0]  in_reg_dst, src_a, src_b;

   logic        o1_valid, o1_we, o1_hit_a, o1_hit_b, o1_busy;
   logic [31:0] o1_wdata, o1_fwd_a, o1_fwd_b;
   logic [4:0]  o1_dst;
   logic        o2_valid, o2_we, o2_hit_a, o2_hit_b, o2_busy;
   logic [31:0] o2_wdata, o2_fwd_a, o2_fwd_b;
   logic [4:0]  o2_dst;
   logic        o3_valid, o3_we, o3_hit_a, o3_hit_b, o3_busy;
   logic [31:0] o3_wdata, o3_fwd_a, o3_fwd_b;
   logic [4:0]  o3_dst;

   typedef struct {
      logic [4:0]  dst;
      logic [31:0] data;
   } wr_t;

   wr_t exp_q[$];
   bit  sb_on = 1'b0;
   int  total = 0;
   int  bad   = 0;

   always #5 clk = ~clk;

   wb_pipe_reg #(.DATA_W(32), .REG_W(5), .DEPTH(1)) u1 (
      .clk(clk), .rst(rst), .stall(stall), .flush(flush),
      .in_valid(in_valid), .in_we(in_we), .in_mem_to_reg(in_mem_to_reg),
      .in_read_data(in_read_data), .in_result(in_result), .in_reg_dst(in_reg_dst),
      .src_a(src_a), .src_b(src_b),
      .out_valid(o1_valid), .out_we(o1_we), .out_wdata(o1_wdata), .out_reg_dst(o1_dst),
      .hit_a(o1_hit_a), .hit_b(o1_hit_b), .fwd_a(o1_fwd_a), .fwd_b(o1_fwd_b), .busy(o1_busy)
   );

   wb_pipe_reg #(.DATA_W(32), .REG_W(5), .DEPTH(2)) u2 (
      .clk(clk), .rst(rst), .stall(stall), .flush(flush),
      .in_valid(in_valid), .in_we(in_we), .in_mem_to_reg(in_mem_to_reg),
      .in_read_data(in_read_data), .in_result(in_result), .in_reg_dst(in_reg_dst),
      .src_a(src_a), .src_b(src_b),
      .out_valid(o2_valid), .out_we(o2_we), .out_wdata(o2_wdata), .out_reg_dst(o2_dst),
      .hit_a(o2_hit_a), .hit_b(o2_hit_b), .fwd_a(o2_fwd_a), .fwd_b(o2_fwd_b), .busy(o2_busy)
   );

   wb_pipe_reg #(.DATA_W(32), .REG_W(5), .DEPTH(3)) u3 (
      .clk(clk), .rst(rst), .stall(stall), .flush(flush),
      .in_valid(in_valid), .in_we(in_we), .in_mem_to_reg(in_mem_to_reg),
      .in_read_data(in_read_data), .in_result(in_result), .in_reg_dst(in_reg_dst),
      .src_a(src_a), .src_b(src_b),
      .out_valid(o3_valid), .out_we(o3_we), .out_wdata(o3_wdata), .out_reg_dst(o3_dst),
      .hit_a(o3_hit_a), .hit_b(o3_hit_b), .fwd_a(o3_fwd_a), .fwd_b(o3_fwd_b), .busy(o3_busy)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // One clock edge, then compare any DEPTH=3 write against the scoreboard.
   task automatic tick();
      wr_t w;
      @(posedge clk);
      #1;
      if (sb_on && o3_we) begin
         if (exp_q.size() == 0) begin
            chk("sb_unexpected_we", {31'b0, o3_we}, 32'h0);
         end else begin
            w = exp_q.pop_front();
            chk("sb_dst", {27'b0, o3_dst}, {27'b0, w.dst});
            chk("sb_data", o3_wdata, w.data);
         end
      end
   endtask

   task automatic drive(input logic v, input logic we, input logic m2r,
                        input logic [31:0] rd, input logic [31:0] res, input logic [4:0] dst);
      in_valid      = v;
      in_we         = we;
      in_mem_to_reg = m2r;
      in_read_data  = rd;
      in_result     = res;
      in_reg_dst    = dst;
   endtask

   task automatic push(input logic [4:0] dst, input logic [31:0] data);
      wr_t w;
      w.dst  = dst;
      w.data = data;
      exp_q.push_back(w);
   endtask

   task automatic do_reset();
      rst = 1'b1;
      tick();
      rst = 1'b0;
   endtask

   initial begin
      rst = 1'b1; stall = 1'b0; flush = 1'b0;
      src_a = 5'd0; src_b = 5'd0;
      drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 5'd0);

      // Reset for two edges, all outputs zero.
      tick();
      tick();
      rst = 1'b0;
      src_a = 5'd5;
      #1;
      chk("rst_valid", {31'b0, o1_valid}, 32'h0);
      chk("rst_we", {31'b0, o1_we}, 32'h0);
      chk("rst_wdata", o1_wdata, 32'h0);
      chk("rst_dst", {27'b0, o1_dst}, 32'h0);
      chk("rst_hit_a", {31'b0, o1_hit_a}, 32'h0);
      chk("rst_hit_b", {31'b0, o1_hit_b}, 32'h0);
      chk("rst_fwd_a", o1_fwd_a, 32'h0);
      chk("rst_fwd_b", o1_fwd_b, 32'h0);
      chk("rst_busy1", {31'b0, o1_busy}, 32'h0);
      chk("rst_busy2", {31'b0, o2_busy}, 32'h0);
      chk("rst_busy3", {31'b0, o3_busy}, 32'h0);

      // DEPTH=1 basic write of result.
      drive(1'b1, 1'b1, 1'b0, 32'h0, 32'h0000_00AA, 5'd5);
      tick();
      chk("d1_valid", {31'b0, o1_valid}, 32'h1);
      chk("d1_we", {31'b0, o1_we}, 32'h1);
      chk("d1_wdata", o1_wdata, 32'h0000_00AA);
      chk("d1_dst", {27'b0, o1_dst}, 32'd5);
      chk("d1_hit_a", {31'b0, o1_hit_a}, 32'h1);
      chk("d1_fwd_a", o1_fwd_a, 32'h0000_00AA);
      chk("d1_hit_b0", {31'b0, o1_hit_b}, 32'h0);

      // Read-data select and write to $0 suppressed.
      drive(1'b1, 1'b1, 1'b1, 32'hDEAD_BEEF, 32'h1, 5'd0);
      src_a = 5'd0;
      tick();
      chk("mux_wdata", o1_wdata, 32'hDEAD_BEEF);
      chk("mux_valid", {31'b0, o1_valid}, 32'h1);
      chk("zero_we", {31'b0, o1_we}, 32'h0);

      // Bubble: we set but not valid.
      drive(1'b0, 1'b1, 1'b0, 32'h0, 32'h44, 5'd4);
      src_a = 5'd4;
      tick();
      chk("bub_we", {31'b0, o1_we}, 32'h0);
      chk("bub_valid", {31'b0, o1_valid}, 32'h0);
      chk("bub_hit_a", {31'b0, o1_hit_a}, 32'h0);
      chk("bub_fwd_a", o1_fwd_a, 32'h0);
      chk("bub_busy", {31'b0, o1_busy}, 32'h0);

      // DEPTH=3 stall: A, B issued, two stall edges with C held, then release.
      src_a = 5'd0;
      do_reset();
      sb_on = 1'b1;
      drive(1'b1, 1'b1, 1'b0, 32'h0, 32'h100, 5'd1); push(5'd1, 32'h100);
      tick();
      drive(1'b1, 1'b1, 1'b0, 32'h0, 32'h200, 5'd2); push(5'd2, 32'h200);
      tick();
      drive(1'b1, 1'b1, 1'b1, 32'h300, 32'hBAD, 5'd3); push(5'd3, 32'h300);
      stall = 1'b1;
      tick();
      chk("stl_valid_e2", {31'b0, o3_valid}, 32'h0);
      chk("stl_busy_e2", {31'b0, o3_busy}, 32'h1);
      tick();
      chk("stl_valid_e3", {31'b0, o3_valid}, 32'h0);
      stall = 1'b0;
      tick();
      chk("stl_a_we", {31'b0, o3_we}, 32'h1);
      chk("stl_a_dst", {27'b0, o3_dst}, 32'd1);
      in_valid = 1'b0;
      tick();
      chk("stl_b_dst", {27'b0, o3_dst}, 32'd2);
      tick();
      chk("stl_c_dst", {27'b0, o3_dst}, 32'd3);
      chk("stl_c_wdata", o3_wdata, 32'h300);
      tick();
      chk("stl_drain_busy", {31'b0, o3_busy}, 32'h0);
      chk("stl_sb_left", exp_q.size(), 32'h0);

      // DEPTH=3 flush together with stall while B and C are in flight.
      drive(1'b1, 1'b1, 1'b0, 32'h0, 32'h400, 5'd1); push(5'd1, 32'h400);
      tick();
      drive(1'b1, 1'b1, 1'b0, 32'h0, 32'h500, 5'd2);
      tick();
      drive(1'b1, 1'b1, 1'b0, 32'h0, 32'h600, 5'd3);
      tick();
      in_valid = 1'b0;
      stall = 1'b1;
      flush = 1'b1;
      tick();
      chk("fl_busy", {31'b0, o3_busy}, 32'h0);
      chk("fl_we", {31'b0, o3_we}, 32'h0);
      stall = 1'b0;
      flush = 1'b0;
      tick();
      tick();
      tick();
      chk("fl_sb_left", exp_q.size(), 32'h0);

      // DEPTH=3 forwarding: stage0 dst7/0x22, stage1 dst9/0x55, stage2 dst7/0x11.
      drive(1'b1, 1'b1, 1'b0, 32'h0, 32'h11, 5'd7); push(5'd7, 32'h11);
      tick();
      drive(1'b1, 1'b1, 1'b1, 32'h55, 32'h0, 5'd9); push(5'd9, 32'h55);
      tick();
      drive(1'b1, 1'b1, 1'b0, 32'h0, 32'h22, 5'd7); push(5'd7, 32'h22);
      src_a = 5'd7;
      src_b = 5'd0;
      tick();
      chk("fw_hit_a", {31'b0, o3_hit_a}, 32'h1);
      chk("fw_fwd_a", o3_fwd_a, 32'h22);
      chk("fw_hit_b0", {31'b0, o3_hit_b}, 32'h0);
      chk("fw_fwd_b0", o3_fwd_b, 32'h0);
      src_b = 5'd9;
      #1;
      chk("fw_hit_b9", {31'b0, o3_hit_b}, 32'h1);
      chk("fw_fwd_b9", o3_fwd_b, 32'h55);
      in_valid = 1'b0;
      tick();
      tick();
      tick();
      chk("fw_sb_left", exp_q.size(), 32'h0);
      sb_on = 1'b0;

      // DEPTH=2 reset mid-stream: P in stage 0, Q presented with rst.
      src_a = 5'd0;
      src_b = 5'd0;
      do_reset();
      drive(1'b1, 1'b1, 1'b0, 32'h0, 32'h77, 5'd10);
      tick();
      chk("rm_busy_pre", {31'b0, o2_busy}, 32'h1);
      chk("rm_we_pre", {31'b0, o2_we}, 32'h0);
      drive(1'b1, 1'b1, 1'b0, 32'h0, 32'h88, 5'd11);
      rst = 1'b1;
      tick();
      chk("rm_busy", {31'b0, o2_busy}, 32'h0);
      chk("rm_we", {31'b0, o2_we}, 32'h0);
      chk("rm_valid", {31'b0, o2_valid}, 32'h0);
      rst = 1'b0;
      in_valid = 1'b0;
      tick();
      chk("rm_we_post1", {31'b0, o2_we}, 32'h0);
      tick();
      chk("rm_we_post2", {31'b0, o2_we}, 32'h0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
